// File: rtl/comm_pkg.sv
// Shared serial-link definitions for the move transmitter and receiver:
// default baud constants, receiver state encoding and the bit-vote helper.
package comm_pkg;

    localparam int CLK_HZ       = 65_000_000;
    localparam int BAUD_RATE    = 9600;
    localparam int SAMP_PER_BIT = 16;
    localparam int CLK_PER_SAMP = CLK_HZ / (BAUD_RATE * SAMP_PER_BIT);

    // Oversample positions (1-based tick count within a bit) that decide the bit.
    localparam int VOTE_SAMP_A = 7;
    localparam int VOTE_SAMP_B = 8;
    localparam int VOTE_SAMP_C = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so the output can start at the line's idle level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make meta and q a true two-stage shift;
    // blocking ones here would collapse the chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/move_rx.sv
// Serial move receiver: oversampled start/data/stop decoder with 2-of-3
// bit voting, false-start rejection and stop-bit error reporting.
module move_rx #(
    parameter int PKT_LEN      = 8,
    parameter int SAMP_PER_BIT = comm_pkg::SAMP_PER_BIT,
    parameter int CLK_PER_SAMP = comm_pkg::CLK_PER_SAMP
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rx,
    output logic               ready,
    output logic [PKT_LEN-1:0] data_out,
    output logic               frame_err,
    output logic               busy
);

    import comm_pkg::*;

    localparam int CLK_W  = $clog2(CLK_PER_SAMP);
    localparam int SAMP_W = $clog2(SAMP_PER_BIT + 1);
    localparam int BIT_W  = $clog2(PKT_LEN);

    localparam logic [CLK_W-1:0]  CLK_LAST  = CLK_W'(CLK_PER_SAMP - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(SAMP_PER_BIT);
    localparam logic [SAMP_W-1:0] VOTE_A    = SAMP_W'(VOTE_SAMP_A);
    localparam logic [SAMP_W-1:0] VOTE_B    = SAMP_W'(VOTE_SAMP_B);
    localparam logic [SAMP_W-1:0] VOTE_C    = SAMP_W'(VOTE_SAMP_C);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PKT_LEN - 1);

    logic rx_s;
    logic rx_q;

    rx_state_t          state,     state_nxt;
    logic [CLK_W-1:0]   clk_cnt,   clk_cnt_nxt;
    logic [SAMP_W-1:0]  samp_cnt,  samp_cnt_nxt;
    logic [BIT_W-1:0]   bit_cnt,   bit_cnt_nxt;
    logic [1:0]         votes,     votes_nxt;
    logic [PKT_LEN-1:0] shift_reg, shift_nxt;
    logic [PKT_LEN-1:0] dout_nxt;
    logic               ready_nxt;
    logic               err_nxt;

    logic              fall;
    logic              tick;
    logic [SAMP_W-1:0] samp_next;
    logic              at_vote;
    logic              bit_end;
    logic              vote_bit;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk_in),
        .rst_n (rst_in),
        .d     (rx),
        .q     (rx_s)
    );

    assign fall      = rx_q & ~rx_s;
    assign tick      = (clk_cnt == CLK_LAST);
    assign samp_next = samp_cnt + 1'b1;
    assign at_vote   = tick && (samp_next == VOTE_C);
    assign bit_end   = tick && (samp_next == SAMP_LAST);
    // votes holds samples A and B; sample C is the live synchronized level.
    assign vote_bit  = majority3(votes[1], votes[0], rx_s);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_q      <= 1'b1;
            state     <= IDLE;
            clk_cnt   <= '0;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            votes     <= '0;
            shift_reg <= '0;
            data_out  <= '0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_q      <= rx_s;
            state     <= state_nxt;
            clk_cnt   <= clk_cnt_nxt;
            samp_cnt  <= samp_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            votes     <= votes_nxt;
            shift_reg <= shift_nxt;
            data_out  <= dout_nxt;
            ready     <= ready_nxt;
            frame_err <= err_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_nxt    = state;
        samp_cnt_nxt = samp_cnt;
        bit_cnt_nxt  = bit_cnt;
        votes_nxt    = votes;
        shift_nxt    = shift_reg;
        dout_nxt     = data_out;
        ready_nxt    = 1'b0;
        err_nxt      = 1'b0;
        clk_cnt_nxt  = tick ? '0 : clk_cnt + 1'b1;

        if (tick && (state inside {START, DATA, STOP}) &&
            (samp_next == VOTE_A || samp_next == VOTE_B)) begin
            votes_nxt = {votes[0], rx_s};
        end

        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt    = START;
                    clk_cnt_nxt  = '0;
                    samp_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                end
            end

            START: begin
                if (tick) samp_cnt_nxt = samp_next;
                if (at_vote && vote_bit) begin
                    state_nxt    = IDLE;
                    samp_cnt_nxt = '0;
                end else if (bit_end) begin
                    state_nxt    = DATA;
                    samp_cnt_nxt = '0;
                end
            end

            DATA: begin
                if (tick) samp_cnt_nxt = samp_next;
                if (at_vote) shift_nxt = {vote_bit, shift_reg[PKT_LEN-1:1]};
                if (bit_end) begin
                    samp_cnt_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt   = STOP;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end

            STOP: begin
                if (tick) samp_cnt_nxt = samp_next;
                // Decide at the vote and leave early so a following start
                // edge at the end of the stop bit is not missed.
                if (at_vote) begin
                    samp_cnt_nxt = '0;
                    if (vote_bit) begin
                        dout_nxt  = shift_reg;
                        ready_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                if (tick) begin
                    if (!rx_s) begin
                        samp_cnt_nxt = '0;
                    end else if (samp_next == SAMP_LAST) begin
                        samp_cnt_nxt = '0;
                        state_nxt    = IDLE;
                    end else begin
                        samp_cnt_nxt = samp_next;
                    end
                end
            end

            default: begin
                state_nxt    = IDLE;
                samp_cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_move_rx.sv
// Self-checking bench for move_rx: table of frames plus hand-written false
// start, back-to-back and mid-frame reset sequences, scored via a queue.
module tb_move_rx;

    localparam int PKT_LEN = 8;
    localparam int SPB     = 16;
    localparam int CPS     = 16;
    localparam int BIT_CYC = SPB * CPS;
    localparam int LAT_NOM = (19 * BIT_CYC) / 2 + 3;
    localparam int GL_LO   = 8 * CPS - CPS / 2;
    localparam int GL_HI   = 8 * CPS + CPS / 2;

    logic               clk_in = 1'b0;
    logic               rst_in = 1'b0;
    logic               rx     = 1'b1;
    logic               ready;
    logic               frame_err;
    logic               busy;
    logic [PKT_LEN-1:0] data_out;

    move_rx #(
        .PKT_LEN      (PKT_LEN),
        .SAMP_PER_BIT (SPB),
        .CLK_PER_SAMP (CPS)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rx        (rx),
        .ready     (ready),
        .data_out  (data_out),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         glitch_bit;
        logic       exp_ready;
        logic       exp_err;
        logic [7:0] exp_dout;
    } vec_t;

    longint     cyc = 0;
    longint     fall_cyc = 0;
    int         n_ready = 0;
    int         n_err = 0;
    logic       ready_d = 1'b0;
    logic       err_d = 1'b0;
    logic       rst_d = 1'b0;
    logic [7:0] dout_d = '0;

    always @(posedge clk_in) cyc++;

    // Output monitor: pops the scoreboard on each pulse and polices pulse rules.
    always @(negedge clk_in) begin
        exp_t   e;
        longint lat;
        if (rst_in && rst_d) begin
            if (ready) begin
                n_ready++;
                lat = cyc - fall_cyc;
                check("ready_width", ready_d, 0);
                check("ready_err_excl", frame_err, 0);
                check("ready_latency", (lat >= LAT_NOM - CPS) && (lat <= LAT_NOM + CPS), 1);
                check("ready_queued", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("ready_kind", e.is_err, 0);
                    check("ready_data", data_out, e.data);
                end
            end
            if (frame_err) begin
                n_err++;
                check("err_width", err_d, 0);
                check("err_queued", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("err_kind", e.is_err, 1);
                    check("err_dout_hold", data_out, e.data);
                end
            end
            if (!ready && data_out !== dout_d) check("dout_hold", data_out, dout_d);
        end
        ready_d = ready;
        err_d   = frame_err;
        rst_d   = rst_in;
        dout_d  = data_out;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk_in);
    endtask

    // Drives start, data (LSB first) and stop; optional one-sample glitch
    // centred on sample 8 of data bit glitch_bit, optional reset in abort_bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input int glitch_bit, input int abort_bit);
        logic [9:0] bits;
        bits = {stop_val, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < BIT_CYC; c++) begin
                @(negedge clk_in);
                if (b == 0 && c == 0) fall_cyc = cyc;
                if (abort_bit >= 0 && b == abort_bit + 1 && c == BIT_CYC / 2) begin
                    rx     = 1'b1;
                    rst_in = 1'b0;
                    repeat (4) @(negedge clk_in);
                    check("abort_ready", ready, 0);
                    check("abort_err", frame_err, 0);
                    check("abort_busy", busy, 0);
                    check("abort_dout", data_out, 0);
                    rst_in = 1'b1;
                    return;
                end
                if (glitch_bit >= 0 && b == glitch_bit + 1 && c >= GL_LO && c < GL_HI)
                    rx = ~bits[b];
                else
                    rx = bits[b];
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   r0;
        int   e0;

        vecs[0] = '{8'hA5, 1'b1, -1, 1'b1, 1'b0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, -1, 1'b0, 1'b1, 8'hA5};
        vecs[2] = '{8'h11, 1'b1, -1, 1'b1, 1'b0, 8'h11};
        vecs[3] = '{8'h81, 1'b1,  3, 1'b1, 1'b0, 8'h81};
        vecs[4] = '{8'hC3, 1'b1,  0, 1'b1, 1'b0, 8'hC3};
        vecs[5] = '{8'h7E, 1'b1,  6, 1'b1, 1'b0, 8'h7E};

        // Reset state, then release on an idle line: no spurious start.
        repeat (5) @(negedge clk_in);
        check("rst_ready", ready, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_dout", data_out, 0);
        rst_in = 1'b1;
        idle(2 * BIT_CYC);
        check("release_busy", busy, 0);
        check("release_pulses", n_ready + n_err, 0);

        for (int i = 0; i < 6; i++) begin
            r0 = n_ready;
            e0 = n_err;
            if (vecs[i].exp_ready || vecs[i].exp_err)
                sb.push_back('{is_err: vecs[i].exp_err, data: vecs[i].exp_dout});
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].glitch_bit, -1);
            idle(2 * BIT_CYC);
            check($sformatf("vec%0d_ready", i), n_ready - r0, 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_err", i), n_err - e0, 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_dout", i), data_out, vecs[i].exp_dout);
            check($sformatf("vec%0d_idle", i), busy, 0);
        end

        // False start: 100-cycle low glitch ends before the first vote sample.
        r0 = n_ready;
        e0 = n_err;
        rx = 1'b0;
        repeat (50) @(negedge clk_in);
        check("glitch_busy", busy, 1);
        repeat (50) @(negedge clk_in);
        idle(2 * BIT_CYC);
        check("glitch_idle", busy, 0);
        check("glitch_pulses", (n_ready - r0) + (n_err - e0), 0);
        check("glitch_dout", data_out, 8'h7E);

        // Back-to-back frames with no idle gap.
        r0 = n_ready;
        sb.push_back('{is_err: 1'b0, data: 8'h00});
        sb.push_back('{is_err: 1'b0, data: 8'hFF});
        send_frame(8'h00, 1'b1, -1, -1);
        check("b2b_first", data_out, 8'h00);
        send_frame(8'hFF, 1'b1, -1, -1);
        idle(2 * BIT_CYC);
        check("b2b_count", n_ready - r0, 2);
        check("b2b_second", data_out, 8'hFF);

        // Reset during data bit 4, then a clean frame.
        r0 = n_ready;
        e0 = n_err;
        send_frame(8'hC7, 1'b1, -1, 4);
        idle(2 * BIT_CYC);
        check("abort_pulses", (n_ready - r0) + (n_err - e0), 0);
        sb.push_back('{is_err: 1'b0, data: 8'h5A});
        send_frame(8'h5A, 1'b1, -1, -1);
        idle(2 * BIT_CYC);
        check("after_abort_ready", n_ready - r0, 1);
        check("after_abort_dout", data_out, 8'h5A);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
